// File: rtl/sc_level_counter.sv
// sc_level_counter: bounded up/down level counter with edge-triggered
// step requests, parallel load and a saturate or wrap policy at the bounds.
// All outputs come straight from flops.
// Optional feature: define SC_LEVELCOUNTER_CLEAR_EN to add a synchronous
// clear input that takes priority over load.
module sc_level_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_VALUE = 9,
   parameter int WRAP_MODE = 0
) (
   input  logic             SC_LEVELCOUNTER_CLOCK_50,
   input  logic             SC_LEVELCOUNTER_RESET_InLow,
`ifdef SC_LEVELCOUNTER_CLEAR_EN
   input  logic             SC_LEVELCOUNTER_clear_InHigh,
`endif
   input  logic             SC_LEVELCOUNTER_up_InHigh,
   input  logic             SC_LEVELCOUNTER_down_InHigh,
   input  logic             SC_LEVELCOUNTER_load_InHigh,
   input  logic [WIDTH-1:0] SC_LEVELCOUNTER_data_InBus,
   output logic [WIDTH-1:0] SC_LEVELCOUNTER_count_OutBus,
   output logic             SC_LEVELCOUNTER_max_OutHigh,
   output logic             SC_LEVELCOUNTER_zero_OutHigh,
   output logic             SC_LEVELCOUNTER_wrap_OutHigh,
   output logic             SC_LEVELCOUNTER_changed_OutHigh
);

   localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VALUE);
   localparam logic [WIDTH-1:0] ZERO_C = '0;
   localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
   localparam bit               WRAP_C = (WRAP_MODE != 0);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic             wrap_nxt;
   logic             up_prev;
   logic             down_prev;
   logic             up_evt;
   logic             down_evt;
   logic             clear;

`ifdef SC_LEVELCOUNTER_CLEAR_EN
   assign clear = SC_LEVELCOUNTER_clear_InHigh;
`else
   assign clear = 1'b0;
`endif

   // A request counts once, on the cycle it rises.
   assign up_evt   = SC_LEVELCOUNTER_up_InHigh   & ~up_prev;
   assign down_evt = SC_LEVELCOUNTER_down_InHigh & ~down_prev;

   // Next count and wrap flag, resolved in priority order.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
      count_nxt = count_q;
      wrap_nxt  = 1'b0;
      if (clear) begin
         count_nxt = ZERO_C;
      end else if (SC_LEVELCOUNTER_load_InHigh) begin
         count_nxt = (SC_LEVELCOUNTER_data_InBus > MAX_C) ? MAX_C
                                                          : SC_LEVELCOUNTER_data_InBus;
      end else if (up_evt && down_evt) begin
         count_nxt = count_q;
      end else if (up_evt) begin
         if (count_q < MAX_C) begin
            count_nxt = count_q + ONE_C;
         end else if (WRAP_C) begin
            count_nxt = ZERO_C;
            wrap_nxt  = 1'b1;
         end
      end else if (down_evt) begin
         if (count_q > ZERO_C) begin
            count_nxt = count_q - ONE_C;
         end else if (WRAP_C) begin
            count_nxt = MAX_C;
            wrap_nxt  = 1'b1;
         end
      end
   end

   // Count, flags, pulses and edge history; flags are derived from the next
   // count so they stay coherent with the registered count.
   always_ff @(posedge SC_LEVELCOUNTER_CLOCK_50 or negedge SC_LEVELCOUNTER_RESET_InLow) begin
      if (!SC_LEVELCOUNTER_RESET_InLow) begin
         count_q                         <= '0;
         up_prev                         <= 1'b0;
         down_prev                       <= 1'b0;
         SC_LEVELCOUNTER_max_OutHigh     <= 1'b0;
         SC_LEVELCOUNTER_zero_OutHigh    <= 1'b1;
         SC_LEVELCOUNTER_wrap_OutHigh    <= 1'b0;
         SC_LEVELCOUNTER_changed_OutHigh <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         count_q                         <= count_nxt;
         up_prev                         <= SC_LEVELCOUNTER_up_InHigh;
         down_prev                       <= SC_LEVELCOUNTER_down_InHigh;
         SC_LEVELCOUNTER_max_OutHigh     <= (count_nxt == MAX_C);
         SC_LEVELCOUNTER_zero_OutHigh    <= (count_nxt == ZERO_C);
         SC_LEVELCOUNTER_wrap_OutHigh    <= wrap_nxt;
         SC_LEVELCOUNTER_changed_OutHigh <= (count_nxt != count_q);
      end
   end

   assign SC_LEVELCOUNTER_count_OutBus = count_q;

endmodule

// File: tb/tb_sc_level_counter.sv
// Directed bench for sc_level_counter: one saturating and one wrapping
// instance share the same stimulus; expected values are hand-computed.
module tb_sc_level_counter;

   logic       clk;
   logic       rst_n;
   logic       up;
   logic       down;
   logic       load;
   logic [3:0] data;

   logic [3:0] cnt_s, cnt_w;
   logic       max_s, zero_s, wrap_s, chg_s;
   logic       max_w, zero_w, wrap_w, chg_w;

   int n_checks = 0;
   int n_fail   = 0;

   sc_level_counter #(.WIDTH(4), .MAX_VALUE(9), .WRAP_MODE(0)) u_sat (
      .SC_LEVELCOUNTER_CLOCK_50        (clk),
      .SC_LEVELCOUNTER_RESET_InLow     (rst_n),
`ifdef SC_LEVELCOUNTER_CLEAR_EN
      .SC_LEVELCOUNTER_clear_InHigh    (1'b0),
`endif
      .SC_LEVELCOUNTER_up_InHigh       (up),
      .SC_LEVELCOUNTER_down_InHigh     (down),
      .SC_LEVELCOUNTER_load_InHigh     (load),
      .SC_LEVELCOUNTER_data_InBus      (data),
      .SC_LEVELCOUNTER_count_OutBus    (cnt_s),
      .SC_LEVELCOUNTER_max_OutHigh     (max_s),
      .SC_LEVELCOUNTER_zero_OutHigh    (zero_s),
      .SC_LEVELCOUNTER_wrap_OutHigh    (wrap_s),
      .SC_LEVELCOUNTER_changed_OutHigh (chg_s)
   );

   sc_level_counter #(.WIDTH(4), .MAX_VALUE(9), .WRAP_MODE(1)) u_wrap (
      .SC_LEVELCOUNTER_CLOCK_50        (clk),
      .SC_LEVELCOUNTER_RESET_InLow     (rst_n),
`ifdef SC_LEVELCOUNTER_CLEAR_EN
      .SC_LEVELCOUNTER_clear_InHigh    (1'b0),
`endif
      .SC_LEVELCOUNTER_up_InHigh       (up),
      .SC_LEVELCOUNTER_down_InHigh     (down),
      .SC_LEVELCOUNTER_load_InHigh     (load),
      .SC_LEVELCOUNTER_data_InBus      (data),
      .SC_LEVELCOUNTER_count_OutBus    (cnt_w),
      .SC_LEVELCOUNTER_max_OutHigh     (max_w),
      .SC_LEVELCOUNTER_zero_OutHigh    (zero_w),
      .SC_LEVELCOUNTER_wrap_OutHigh    (wrap_w),
      .SC_LEVELCOUNTER_changed_OutHigh (chg_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change at a falling edge; one tick crosses a rising edge and
   // lands on the next falling edge, where outputs are sampled.
   task automatic tick();
      @(negedge clk);
   endtask

   int exp_cnt2 [10] = '{8, 8, 9, 9, 9, 9, 9, 9, 9, 9};
   int exp_chg2 [10] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      int n_chg;
      int n_wrap;
      rst_n = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; data = 4'd0;
      tick(); tick();

      // Reset state
      check("rst count", cnt_s, 0);
      check("rst zero", zero_s, 1);
      check("rst max", max_s, 0);
      check("rst wrap", wrap_s, 0);
      check("rst changed", chg_s, 0);

      // 1: up held for five cycles steps exactly once
      rst_n = 1'b1;
      tick();
      up = 1'b1;
      tick();
      check("t1 count step", cnt_s, 1);
      check("t1 changed", chg_s, 1);
      check("t1 zero low", zero_s, 0);
      tick();
      check("t1 changed once", chg_s, 0);
      tick(); tick(); tick();
      check("t1 count held", cnt_s, 1);

      // 2: saturate at MAX after five pulses from 7
      up = 1'b0; load = 1'b1; data = 4'd7;
      tick();
      check("t2 load 7", cnt_s, 7);
      check("t2 load 7 wrapinst", cnt_w, 7);
      load = 1'b0;
      n_chg  = 0;
      n_wrap = 0;
      for (int i = 0; i < 10; i++) begin
         up = (i % 2 == 0);
         tick();
         check($sformatf("t2 count step%0d", i), cnt_s, exp_cnt2[i]);
         check($sformatf("t2 changed step%0d", i), chg_s, exp_chg2[i]);
         n_chg  += int'(chg_s);
         n_wrap += int'(wrap_s);
      end
      check("t2 max at 9", max_s, 1);
      check("t2 changed total", n_chg, 2);
      check("t2 wrap never", n_wrap, 0);
      // Wrap instance went 7 ->8 ->9 ->0 ->1 ->2 on the five pulses
      check("t2 wrapinst count", cnt_w, 2);

      // 3: wrap up at MAX and wrap down at 0
      up = 1'b0; load = 1'b1; data = 4'd9;
      tick();
      check("t3 load 9", cnt_w, 9);
      check("t3 load max", max_w, 1);
      load = 1'b0; up = 1'b1;
      tick();
      check("t3 wrap up count", cnt_w, 0);
      check("t3 wrap up pulse", wrap_w, 1);
      check("t3 wrap up changed", chg_w, 1);
      check("t3 wrap up zero", zero_w, 1);
      check("t3 sat hold count", cnt_s, 9);
      check("t3 sat hold changed", chg_s, 0);
      check("t3 sat no wrap", wrap_s, 0);
      up = 1'b0;
      tick();
      check("t3 wrap pulse ends", wrap_w, 0);
      check("t3 changed ends", chg_w, 0);
      down = 1'b1;
      tick();
      check("t3 wrap down count", cnt_w, 9);
      check("t3 wrap down pulse", wrap_w, 1);
      check("t3 sat down count", cnt_s, 8);
      down = 1'b0;
      tick();
      check("t3 wrap down ends", wrap_w, 0);

      // 4: load clamps above MAX; reload of same value is silent
      load = 1'b1; data = 4'hC;
      tick();
      check("t4 clamp count", cnt_s, 9);
      check("t4 clamp max", max_s, 1);
      check("t4 clamp changed", chg_s, 1);
      data = 4'd9;
      tick();
      check("t4 same load count", cnt_s, 9);
      check("t4 same load changed", chg_s, 0);

      // 5: simultaneous up and down edges cancel
      data = 4'd5;
      tick();
      check("t5 load 5", cnt_s, 5);
      load = 1'b0; up = 1'b1; down = 1'b1;
      tick();
      check("t5 both count", cnt_s, 5);
      check("t5 both changed", chg_s, 0);
      tick(); tick(); tick();
      check("t5 both held", cnt_s, 5);
      up = 1'b0; down = 1'b0;
      tick();

      // 6: asynchronous reset between edges, release with up already high
      load = 1'b1; data = 4'd6;
      tick();
      load = 1'b0;
      tick();
      check("t6 count 6", cnt_s, 6);
      #2 rst_n = 1'b0;
      #1;
      check("t6 async count", cnt_s, 0);
      check("t6 async zero", zero_s, 1);
      check("t6 async changed", chg_s, 0);
      up = 1'b1;
      tick();
      check("t6 held in reset", cnt_s, 0);
      rst_n = 1'b1;
      tick();
      check("t6 first edge count", cnt_s, 1);
      check("t6 first edge changed", chg_s, 1);
      tick();
      check("t6 no second step", cnt_s, 1);
      up = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
